// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
// Contents: loader FSM state encoding, bytes-per-word constant, a helper
// that turns the address width into a memory depth in words, and an
// 8-bit wrapping add used by the optional checksum accumulator.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        CSUM   = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } loader_state_e;

    localparam int BYTES_PER_WORD = 4;

    // Number of instruction-memory words addressable with addr_w bits.
    function automatic int loader_depth(input int addr_w);
        return 32'sd1 << addr_w;
    endfunction

    // Modulo-256 add for the running byte sum.
    function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler: little-endian 32-bit shift-in register.
// Ports:
//   clk, reset     - clock, synchronous active-low reset
//   clr            - return the byte index to 0
//   load_en        - shift din in this cycle (byte accepted)
//   din[7:0]       - incoming byte
//   word_next[31:0]- word value including din (valid together with full)
//   full           - pulse: this load_en carries the 4th byte of a word
// Bytes enter at the top and move down, so the first byte of a word ends
// up in bits [7:0] once four bytes have been shifted in.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        load_en,
    input  logic [7:0]  din,
    output logic [31:0] word_next,
    output logic        full
);

    logic [31:0] word_q, word_d;
    logic [1:0]  byte_idx_q, byte_idx_d;

    // Next-state for the shift register and byte index.
    always_comb begin
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        word_next  = {din, word_q[31:8]};
        full       = 1'b0;
        if (clr) begin
            byte_idx_d = 2'd0;
        end else if (load_en) begin
            word_d     = word_next;
            byte_idx_d = byte_idx_q + 2'd1;
            full       = (byte_idx_q == 2'(BYTES_PER_WORD - 1));
        end else begin
            byte_idx_d = byte_idx_q;
        end
    end

    // Assembler state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q     <= 32'd0;
            byte_idx_q <= 2'd0;
        end else begin
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: boot stage that receives a length-prefixed little-endian
// byte stream, writes it word by word into instruction memory and then
// raises and holds the CPU start level.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   rx_valid, rx_data     - incoming byte stream
//   rx_ready              - loader accepts a byte this cycle (registered)
//   imem_we/addr/wdata    - one-cycle word write strobe, address, data
//   start                 - CPU start, held once set
//   busy                  - load in progress
//   err                   - sticky abort indication
// Optional: define LOADER_CHECKSUM_EN to require a trailing checksum byte
// making the mod-256 sum of all header, data and checksum bytes zero.
// All outputs are flops loaded from the next state, so each output is
// valid in the same cycle the FSM sits in the corresponding state.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              start,
    output logic              busy,
    output logic              err
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(loader_depth(ADDR_W));

    loader_state_e     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic [LEN_W-1:0]  len_cand_s;
    logic [LEN_W-1:0]  word_cnt_inc_s;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              accept_s;
    logic              asm_full_s;
    logic [31:0]       asm_word_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    assign accept_s = rx_valid & rx_ready_q;

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clr       (state_q == LEN_HI),
        .load_en   (accept_s && (state_q == DATA)),
        .din       (rx_data),
        .word_next (asm_word_s),
        .full      (asm_full_s)
    );

    // FSM next state, datapath updates and registered-output next values.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        word_cnt_d     = word_cnt_q;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        len_cand_s     = len_q;
        len_cand_s[15:8] = rx_data;
        word_cnt_inc_s = word_cnt_q + LEN_W'(1);
`ifdef LOADER_CHECKSUM_EN
        sum_d          = sum_q;
        if (accept_s && (state_q == LEN_LO || state_q == LEN_HI || state_q == DATA)) begin
            sum_d = csum_add(sum_q, rx_data);
        end else begin
            sum_d = sum_q;
        end
`endif
        case (state_q)
            LEN_LO: begin
                if (accept_s) begin
                    len_d[7:0] = rx_data;
                    state_d    = LEN_HI;
                end else begin
                    state_d = LEN_LO;
                end
            end
            LEN_HI: begin
                if (accept_s) begin
                    len_d = len_cand_s;
                    if (len_cand_s == LEN_W'(0) || len_cand_s > DEPTH_L) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = LEN_HI;
                end
            end
            DATA: begin
                if (asm_full_s) begin
                    state_d      = WRITE;
                    imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                    imem_wdata_d = asm_word_s;
                end else begin
                    state_d = DATA;
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_inc_s;
                if (word_cnt_inc_s == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = RUN;
`endif
                end else begin
                    state_d = DATA;
                end
            end
            CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept_s) begin
                    state_d = (csum_add(sum_q, rx_data) == 8'd0) ? RUN : ERR;
                end else begin
                    state_d = CSUM;
                end
`else
                state_d = ERR;
`endif
            end
            RUN:     state_d = RUN;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase

        rx_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                     (state_d == DATA)   || (state_d == CSUM);
        imem_we_d  = (state_d == WRITE);
        busy_d     = (state_d == DATA) || (state_d == WRITE) || (state_d == CSUM);
        start_d    = (state_d == RUN);
        err_d      = (state_d == ERR);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= LEN_LO;
            len_q        <= '0;
            word_cnt_q   <= '0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            rx_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign start      = start_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader built with ADDR_W=4 (16-word memory),
// so the capacity boundary (len=16 legal, len=17 rejected) is reachable.
module tb_program_loader;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              start;
    logic              busy;
    logic              err;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          gap_en = 1'b0;
    logic [7:0]  tb_sum = 8'd0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    program_loader #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .start      (start),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: record every write seen with the strobe high.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa_q.push_back({28'd0, imem_addr});
            wd_q.push_back(imem_wdata);
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tb_sum = 8'd0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
        chk({tag, "_we"},       {31'd0, imem_we},  32'd0);
        chk({tag, "_start"},    {31'd0, start},    32'd0);
        chk({tag, "_busy"},     {31'd0, busy},     32'd0);
        chk({tag, "_err"},      {31'd0, err},      32'd0);
        chk({tag, "_addr"},     {28'd0, imem_addr}, 32'd0);
        chk({tag, "_wdata"},    imem_wdata,        32'd0);
    endtask

    // Offer one byte; waits (bounded) for rx_ready, optional random gap.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        if (gap_en && ($urandom_range(0, 99) < 30)) begin
            rx_data = 8'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        while (rx_ready !== 1'b1 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 16) chk("rx_ready_wait", 32'd0, 32'd1);
        rx_valid = 1'b1;
        rx_data  = b;
        tb_sum   = tb_sum + b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'd0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic send_header(input logic [15:0] l);
        send_byte(l[7:0]);
        send_byte(l[15:8]);
    endtask

    // Close a successful image (checksum byte when that feature is built).
    task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'd0 - tb_sum);
`endif
    endtask

    task automatic wait_start(input string tag);
        int guard;
        guard = 0;
        while (start !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk(tag, {31'd0, start}, 32'd1);
    endtask

    function automatic logic [31:0] pat(input int i);
        return {8'hA5, 8'(i), 8'h5A, 8'(~i)};
    endfunction

    initial begin
        int base;
        int c0;
        logic [31:0] g_words [3];
        g_words[0] = 32'h11223344;
        g_words[1] = 32'h55667788;
        g_words[2] = 32'h99AABBCC;

        // Reset state.
        @(negedge clk);
        do_reset();
        chk_reset_outputs("rst");

        // len=2, continuous stream: timing and written words.
        base = wa_q.size();
        send_byte(8'h02);
        c0 = cyc;
        chk("busy_in_len_hi", {31'd0, busy}, 32'd0);
        send_byte(8'h00);
        chk("busy_after_hdr", {31'd0, busy}, 32'd1);
        send_word(32'hE3A00005);
        chk("we_first", {31'd0, imem_we}, 32'd1);
        chk("rdy_in_write", {31'd0, rx_ready}, 32'd0);
        send_word(32'hE2801001);
        chk("start_not_yet", {31'd0, start}, 32'd0);
        finish_load();
        wait_start("len2_start");
`ifdef LOADER_CHECKSUM_EN
        chk("len2_start_cycle", 32'(cyc - c0), 32'd12);
`else
        chk("len2_start_cycle", 32'(cyc - c0), 32'd11);
`endif
        chk("len2_busy_drop", {31'd0, busy}, 32'd0);
        chk("len2_rdy_run", {31'd0, rx_ready}, 32'd0);
        chk("len2_nwrites", 32'(wa_q.size() - base), 32'd2);
        chk("len2_a0", wa_q[base],     32'd0);
        chk("len2_d0", wd_q[base],     32'hE3A00005);
        chk("len2_a1", wa_q[base + 1], 32'd1);
        chk("len2_d1", wd_q[base + 1], 32'hE2801001);
        // Bytes offered in RUN are ignored.
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        chk("run_ignore_writes", 32'(wa_q.size() - base), 32'd2);
        chk("run_hold_start", {31'd0, start}, 32'd1);
        chk("run_no_err", {31'd0, err}, 32'd0);
        chk("run_addr_hold", {28'd0, imem_addr}, 32'd1);
        chk("run_wdata_hold", imem_wdata, 32'hE2801001);

        // len=0 header is rejected.
        do_reset();
        base = wa_q.size();
        send_header(16'h0000);
        chk("len0_err", {31'd0, err}, 32'd1);
        chk("len0_start", {31'd0, start}, 32'd0);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        chk("len0_rdy", {31'd0, rx_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("len0_sticky", {31'd0, err}, 32'd1);
        chk("len0_nwrites", 32'(wa_q.size() - base), 32'd0);

        // len=17 exceeds 16-word capacity.
        do_reset();
        send_header(16'd17);
        chk("len17_err", {31'd0, err}, 32'd1);
        chk("len17_start", {31'd0, start}, 32'd0);

        // len=16 fills the whole memory, addresses 0..15.
        do_reset();
        base = wa_q.size();
        send_header(16'd16);
        for (int i = 0; i < 16; i++) send_word(pat(i));
        finish_load();
        wait_start("len16_start");
        chk("len16_err", {31'd0, err}, 32'd0);
        chk("len16_nwrites", 32'(wa_q.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("len16_a%0d", i), wa_q[base + i], 32'(i));
            chk($sformatf("len16_d%0d", i), wd_q[base + i], pat(i));
        end

        // len=3 with random rx_valid gaps.
        do_reset();
        base = wa_q.size();
        gap_en = 1'b1;
        send_header(16'd3);
        for (int i = 0; i < 3; i++) send_word(g_words[i]);
        finish_load();
        gap_en = 1'b0;
        wait_start("gap_start");
        chk("gap_nwrites", 32'(wa_q.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("gap_a%0d", i), wa_q[base + i], 32'(i));
            chk($sformatf("gap_d%0d", i), wd_q[base + i], g_words[i]);
        end

        // Reset in the middle of a word, then a clean len=1 load.
        do_reset();
        send_header(16'd1);
        send_byte(8'h12);
        send_byte(8'h34);
        do_reset();
        chk_reset_outputs("midrst");
        base = wa_q.size();
        send_header(16'd1);
        send_word(32'hCAFEF00D);
        finish_load();
        wait_start("midrst_start");
        chk("midrst_nwrites", 32'(wa_q.size() - base), 32'd1);
        chk("midrst_a0", wa_q[base], 32'd0);
        chk("midrst_d0", wd_q[base], 32'hCAFEF00D);

`ifdef LOADER_CHECKSUM_EN
        // Header 01 00, word 0x00000001: byte sum 0x02, checksum 0xFE.
        do_reset();
        send_header(16'd1);
        send_word(32'h00000001);
        send_byte(8'hFE);
        wait_start("csum_good_start");
        chk("csum_good_err", {31'd0, err}, 32'd0);
        do_reset();
        send_header(16'd1);
        send_word(32'h00000001);
        send_byte(8'hFF);
        chk("csum_bad_err", {31'd0, err}, 32'd1);
        chk("csum_bad_start", {31'd0, start}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
